// File: rtl/udp_rx_tile_pkg.sv
// Shared types and default widths for the UDP receive tile.
// Holds the NoC output controller state encoding and the output flit mux select codes.
package udp_rx_tile_pkg;

    localparam int NOC_DATA_W_DEF = 512;
    localparam int LEN_W_DEF      = 16;
    localparam int FLITS_W_DEF    = 11;

    typedef enum logic [1:0] {
        ST_READY      = 2'd0,
        ST_HDR_FLIT   = 2'd1,
        ST_META_FLIT  = 2'd2,
        ST_DATA_FLITS = 2'd3
    } ctrl_state_e;

    typedef enum logic [1:0] {
        SEL_HDR  = 2'd0,
        SEL_META = 2'd1,
        SEL_DATA = 2'd2
    } flit_sel_e;

endpackage

// File: rtl/udp_rx_noc_out_ctrl.sv
// Sequences one received UDP packet onto the NoC: header flit, meta flit, then payload flits.
// Handshakes: a beat moves on a cycle where val and rdy are both high; val never waits on rdy.
module udp_rx_noc_out_ctrl
    import udp_rx_tile_pkg::*;
#(
    parameter int NOC_DATA_W = NOC_DATA_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int FLITS_W    = FLITS_W_DEF
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               src_udp_rx_hdr_val,
    input  logic [LEN_W-1:0]   src_udp_rx_data_len,
    output logic               udp_rx_src_hdr_rdy,

    input  logic               src_udp_rx_data_val,
    input  logic               src_udp_rx_data_last,
    output logic               udp_rx_src_data_rdy,

    output logic               udp_rx_out_noc0_vrtoc_val,
    input  logic               noc0_vrtoc_udp_rx_out_rdy,

    output logic               ctrl_datap_store_hdr,
    output logic [1:0]         ctrl_datap_flit_sel,
    output logic [FLITS_W-1:0] ctrl_datap_msg_len,
    output logic               ctrl_err,

    output ctrl_state_e        ctrl_state
);

    localparam int BYTES_PER_FLIT = NOC_DATA_W / 8;
    localparam int BPF_LOG        = $clog2(BYTES_PER_FLIT);

    ctrl_state_e        state;
    ctrl_state_e        state_next;
    flit_sel_e          flit_sel;
    logic [FLITS_W-1:0] count;
    logic [FLITS_W-1:0] count_load;
    logic               hdr_accept;
    logic               data_xfer;

    // Round-up division done one bit wider than the length so 2^LEN_W-1 cannot wrap.
    assign count_load = FLITS_W'(({1'b0, src_udp_rx_data_len} + (LEN_W+1)'(BYTES_PER_FLIT - 1)) >> BPF_LOG);

    assign ctrl_datap_flit_sel = flit_sel;
    assign ctrl_state          = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_READY;
            count              <= '0;
            ctrl_datap_msg_len <= '0;
            ctrl_err           <= 1'b0;
        end else begin
            state <= state_next;
            if (hdr_accept) begin
                count              <= count_load;
                ctrl_datap_msg_len <= count_load + FLITS_W'(1);
            end else if (data_xfer) begin
                count <= count - FLITS_W'(1);
            end
            // The count ends the packet; a disagreeing last marker only flags the error.
            if (data_xfer && (src_udp_rx_data_last != (count == FLITS_W'(1)))) begin
                ctrl_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next                = state;
        udp_rx_src_hdr_rdy        = 1'b0;
        udp_rx_src_data_rdy       = 1'b0;
        udp_rx_out_noc0_vrtoc_val = 1'b0;
        ctrl_datap_store_hdr      = 1'b0;
        flit_sel                  = SEL_HDR;
        hdr_accept                = 1'b0;
        data_xfer                 = 1'b0;
        if (rst) begin
            state_next = ST_READY;
        end else begin
            case (state)
                ST_READY: begin
                    udp_rx_src_hdr_rdy = 1'b1;
                    if (src_udp_rx_hdr_val) begin
                        ctrl_datap_store_hdr = 1'b1;
                        hdr_accept           = 1'b1;
                        state_next           = ST_HDR_FLIT;
                    end
                end
                ST_HDR_FLIT: begin
                    udp_rx_out_noc0_vrtoc_val = 1'b1;
                    flit_sel                  = SEL_HDR;
                    if (noc0_vrtoc_udp_rx_out_rdy) begin
                        state_next = ST_META_FLIT;
                    end
                end
                ST_META_FLIT: begin
                    udp_rx_out_noc0_vrtoc_val = 1'b1;
                    flit_sel                  = SEL_META;
                    if (noc0_vrtoc_udp_rx_out_rdy) begin
                        state_next = (count != '0) ? ST_DATA_FLITS : ST_READY;
                    end
                end
                ST_DATA_FLITS: begin
                    flit_sel                  = SEL_DATA;
                    udp_rx_out_noc0_vrtoc_val = src_udp_rx_data_val;
                    udp_rx_src_data_rdy       = noc0_vrtoc_udp_rx_out_rdy;
                    if (src_udp_rx_data_val && noc0_vrtoc_udp_rx_out_rdy) begin
                        data_xfer = 1'b1;
                        if (count == FLITS_W'(1)) begin
                            state_next = ST_READY;
                        end
                    end
                end
                default: begin
                    state_next                = ctrl_state_e'('x);
                    udp_rx_src_hdr_rdy        = 1'bx;
                    udp_rx_src_data_rdy       = 1'bx;
                    udp_rx_out_noc0_vrtoc_val = 1'bx;
                    ctrl_datap_store_hdr      = 1'bx;
                    flit_sel                  = flit_sel_e'('x);
                    hdr_accept                = 1'bx;
                    data_xfer                 = 1'bx;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_rx_noc_out_ctrl.sv
// Bench for udp_rx_noc_out_ctrl: per-packet expected flit sequence from the length rule,
// compared against flits observed on the NoC port.
module tb_udp_rx_noc_out_ctrl;
    import udp_rx_tile_pkg::*;

    localparam int NOC_DATA_W = 512;
    localparam int LEN_W      = 16;
    localparam int FLITS_W    = 11;
    localparam int BPF        = NOC_DATA_W / 8;
    localparam int BUDGET     = 4000;

    logic               clk = 1'b0;
    logic               rst;
    logic               hdr_val;
    logic [LEN_W-1:0]   data_len;
    logic               hdr_rdy;
    logic               data_val;
    logic               data_last;
    logic               data_rdy;
    logic               noc_val;
    logic               noc_rdy;
    logic               store_hdr;
    logic [1:0]         flit_sel;
    logic [FLITS_W-1:0] msg_len;
    logic               err;
    ctrl_state_e        state;

    udp_rx_noc_out_ctrl #(
        .NOC_DATA_W(NOC_DATA_W),
        .LEN_W(LEN_W),
        .FLITS_W(FLITS_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src_udp_rx_hdr_val(hdr_val),
        .src_udp_rx_data_len(data_len),
        .udp_rx_src_hdr_rdy(hdr_rdy),
        .src_udp_rx_data_val(data_val),
        .src_udp_rx_data_last(data_last),
        .udp_rx_src_data_rdy(data_rdy),
        .udp_rx_out_noc0_vrtoc_val(noc_val),
        .noc0_vrtoc_udp_rx_out_rdy(noc_rdy),
        .ctrl_datap_store_hdr(store_hdr),
        .ctrl_datap_flit_sel(flit_sel),
        .ctrl_datap_msg_len(msg_len),
        .ctrl_err(err),
        .ctrl_state(state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];
    int         data_xfers = 0;
    int         data_rdy_cnt = 0;
    int         rdy_mode = 0;
    bit         model_err = 1'b0;
    bit         prev_stall = 1'b0;
    logic [1:0] prev_sel = 2'd0;

    // NoC-side ready pattern: 0 always ready, 1 toggling, 2 random
    initial begin
        noc_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       noc_rdy = 1'b1;
                1:       noc_rdy = ~noc_rdy;
                default: noc_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // monitor: samples mid-cycle, logs the beats that move on the next rising edge
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (noc_val !== 1'b1 || flit_sel !== prev_sel) begin
                    failures++;
                    $display("FAIL stall_hold: val=%b sel=%0d required val=1 sel=%0d", noc_val, flit_sel, prev_sel);
                end
            end
            if (hdr_val) begin
                checks++;
                if (store_hdr !== hdr_rdy) begin
                    failures++;
                    $display("FAIL store_hdr: got %b required %b", store_hdr, hdr_rdy);
                end
            end
            if (noc_val === 1'b1 && noc_rdy) begin
                got_q.push_back(flit_sel);
                if (flit_sel === SEL_DATA) begin
                    checks++;
                    if (!(data_val && data_rdy === 1'b1)) begin
                        failures++;
                        $display("FAIL data_pair: noc flit without source transfer (data_val=%b data_rdy=%b)", data_val, data_rdy);
                    end
                end
            end
            if (data_val && data_rdy === 1'b1) data_xfers++;
            if (data_rdy !== 1'b0) data_rdy_cnt++;
            prev_stall = (noc_val === 1'b1) && !noc_rdy;
            prev_sel   = flit_sel;
        end
    end

    // driver + scoreboard for one packet
    task automatic run_pkt(input int len, input int mode, input bit bad_first, input bit idles);
        int n;
        int got_base;
        int xfer_base;
        int rdy_base;
        int mism;
        bit ok;
        n = (len + BPF - 1) / BPF;
        rdy_mode = mode;
        exp_q.delete();
        exp_q.push_back(SEL_HDR);
        exp_q.push_back(SEL_META);
        for (int i = 0; i < n; i++) exp_q.push_back(SEL_DATA);
        if (bad_first && n > 1) model_err = 1'b1;

        @(posedge clk);
        #1;
        got_base  = got_q.size();
        xfer_base = data_xfers;
        rdy_base  = data_rdy_cnt;
        hdr_val   = 1'b1;
        data_len  = LEN_W'(len);
        ok = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (hdr_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL hdr_accept: hdr_rdy never seen for len=%0d", len);
        end
        @(posedge clk);
        #1;
        hdr_val = 1'b0;
        checks++;
        if (msg_len !== FLITS_W'(n + 1)) begin
            failures++;
            $display("FAIL msg_len: len=%0d got %0d required %0d", len, msg_len, n + 1);
        end

        for (int i = 0; i < n; i++) begin
            if (idles) begin
                for (int k = 0; k < 3 && $urandom_range(0, 2) == 0; k++) begin
                    data_val = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            data_val  = 1'b1;
            data_last = (i == n - 1) || (bad_first && i == 0);
            ok = 1'b0;
            for (int c = 0; c < BUDGET; c++) begin
                @(negedge clk);
                if (data_rdy === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL data_accept: flit %0d of %0d never accepted (len=%0d)", i, n, len);
            end
            @(posedge clk);
            #1;
        end
        data_val  = 1'b0;
        data_last = 1'b0;

        ok = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            if (got_q.size() - got_base >= exp_q.size()) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL completion: len=%0d got %0d flits required %0d", len, got_q.size() - got_base, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (hdr_rdy !== 1'b1 || state !== ST_READY) begin
            failures++;
            $display("FAIL back_to_back: len=%0d hdr_rdy=%b state=%0d required hdr_rdy=1 state=READY", len, hdr_rdy, state);
        end

        mism = 0;
        if (got_q.size() - got_base != exp_q.size()) begin
            mism = 1;
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                if (got_q[got_base + k] !== exp_q[k]) mism++;
            end
        end
        checks++;
        if (mism != 0) begin
            failures++;
            $display("FAIL flit_seq: len=%0d got %0d flits (%0d wrong) required %0d", len, got_q.size() - got_base, mism, exp_q.size());
        end
        checks++;
        if (data_xfers - xfer_base != n) begin
            failures++;
            $display("FAIL data_xfers: len=%0d got %0d required %0d", len, data_xfers - xfer_base, n);
        end
        if (n == 0) begin
            checks++;
            if (data_rdy_cnt != rdy_base) begin
                failures++;
                $display("FAIL zero_len_data_rdy: data_rdy high %0d cycles required 0", data_rdy_cnt - rdy_base);
            end
        end
        checks++;
        if (err !== model_err) begin
            failures++;
            $display("FAIL ctrl_err: len=%0d got %b required %b", len, err, model_err);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        hdr_val = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (hdr_rdy !== 1'b0 || data_rdy !== 1'b0 || noc_val !== 1'b0 || store_hdr !== 1'b0 || flit_sel !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs: hdr_rdy=%b data_rdy=%b val=%b store=%b sel=%0d required 0 0 0 0 0",
                     hdr_rdy, data_rdy, noc_val, store_hdr, flit_sel);
        end
        @(posedge clk);
        #1;
        hdr_val = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        checks++;
        if (hdr_rdy !== 1'b1 || state !== ST_READY || msg_len !== '0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: hdr_rdy=%b state=%0d msg_len=%0d err=%b required 1 READY 0 0",
                     hdr_rdy, state, msg_len, err);
        end
        model_err = 1'b0;
    endtask

    task automatic test_zero_len();
        run_pkt(0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_small_lengths();
        run_pkt(64, 0, 1'b0, 1'b0);
        run_pkt(65, 0, 1'b0, 1'b0);
        run_pkt(1, 2, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        run_pkt(200, 1, 1'b0, 1'b1);
    endtask

    task automatic test_bad_last();
        run_pkt(128, 0, 1'b1, 1'b0);
        run_pkt(64, 0, 1'b0, 1'b0);
    endtask

    task automatic test_max_len();
        run_pkt(65535, 0, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        bit ok;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        hdr_val  = 1'b1;
        data_len = LEN_W'(200);
        ok = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (hdr_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        hdr_val   = 1'b0;
        data_val  = 1'b1;
        data_last = 1'b0;
        for (int c = 0; c < BUDGET && ok; c++) begin
            @(negedge clk);
            if (data_rdy === 1'b1) break;
        end
        @(posedge clk);
        #1;
        checks++;
        if (state !== ST_DATA_FLITS || err !== model_err) begin
            failures++;
            $display("FAIL mid_pkt_state: state=%0d err=%b required DATA_FLITS err=%b", state, err, model_err);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (noc_val !== 1'b0 || data_rdy !== 1'b0 || hdr_rdy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs: val=%b data_rdy=%b hdr_rdy=%b required 0 0 0", noc_val, data_rdy, hdr_rdy);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        data_val = 1'b0;
        model_err = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== ST_READY || noc_val !== 1'b0 || err !== 1'b0 || hdr_rdy !== 1'b1 || msg_len !== '0) begin
            failures++;
            $display("FAIL mid_reset_state: state=%0d val=%b err=%b hdr_rdy=%b msg_len=%0d required READY 0 0 1 0",
                     state, noc_val, err, hdr_rdy, msg_len);
        end
        run_pkt(64, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int p = 0; p < 8; p++) begin
            run_pkt(int'($urandom_range(0, 400)), int'($urandom_range(0, 2)), 1'b0, 1'b1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        hdr_val   = 1'b0;
        data_len  = '0;
        data_val  = 1'b0;
        data_last = 1'b0;
        test_reset();
        test_zero_len();
        test_small_lengths();
        test_stall();
        test_bad_last();
        test_max_len();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/udp_rx_noc_out_ctrl.md
UDP_RX_NOC_OUT_CTRL -- requirements
Module: udp_rx_noc_out_ctrl

Interface
REQ-001 Parameter: NOC_DATA_W, default 512, NoC flit width in bits; bytes per flit = NOC_DATA_W/8, a power of two.
REQ-002 Parameter: LEN_W, default 16, UDP payload length field width in bytes.
REQ-003 Parameter: FLITS_W, default 11, width of flit counters; holds ceil(2^LEN_W-1 / bytes-per-flit)+1.
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 src_udp_rx_hdr_val  in  1  parsed UDP header/meta valid.
REQ-007 src_udp_rx_data_len  in  LEN_W  payload bytes, qualified by hdr_val.
REQ-008 udp_rx_src_hdr_rdy  out  1  header accept.
REQ-009 src_udp_rx_data_val  in  1  payload flit valid.
REQ-010 src_udp_rx_data_last  in  1  final payload flit marker.
REQ-011 udp_rx_src_data_rdy  out  1  payload flit accept.
REQ-012 udp_rx_out_noc0_vrtoc_val  out  1  NoC flit valid.
REQ-013 noc0_vrtoc_udp_rx_out_rdy  in  1  NoC flit accept.
REQ-014 ctrl_datap_store_hdr  out  1  datapath captures header/meta fields this cycle.
REQ-015 ctrl_datap_flit_sel  out  2  output mux: 0 HDR, 1 META, 2 DATA.
REQ-016 ctrl_datap_msg_len  out  FLITS_W  NoC header message length = data flits + 1 (meta flit), stable from accept until return to READY.
REQ-017 ctrl_err  out  1  sticky protocol-error flag.

Function
REQ-018 States: READY, HDR_FLIT, META_FLIT, DATA_FLITS; one state register.
REQ-019 READY: hdr_rdy=1; on hdr_val, store_hdr=1 for that cycle, register data flit count = (len + bytes-per-flit - 1) >> log2(bytes-per-flit), computed in LEN_W+1 bits without overflow; next HDR_FLIT.
REQ-020 HDR_FLIT: noc val=1, flit_sel=HDR; on noc rdy -> META_FLIT; else hold.
REQ-021 META_FLIT: noc val=1, flit_sel=META; on noc rdy -> DATA_FLITS if count>0, else READY.
REQ-022 DATA_FLITS: flit_sel=DATA; noc val = data_val; data_rdy = noc rdy; a transfer requires both; each transfer decrements count; transfer with count==1 -> READY.
REQ-023 noc val shall never depend combinationally on noc rdy; data_rdy and hdr_rdy 0 outside their states.
REQ-024 Once asserted in HDR_FLIT/META_FLIT, noc val holds until accepted.
REQ-025 data_last asserted on a transfer with count!=1, or deasserted on the transfer with count==1, sets ctrl_err; the count governs termination regardless.
REQ-026 Zero-length payload: exactly two NoC flits (HDR, META), msg_len=1, no data handshake.
REQ-027 Back-to-back packets: hdr_rdy reasserts the cycle after the final transfer; no idle cycle is inserted beyond READY.
REQ-028 Illegal state encoding drives outputs X and next state X in simulation.

Reset
REQ-029 rst forces state READY, count 0, msg_len 0, ctrl_err 0, from the next clock edge, including mid-packet.
REQ-030 During reset cycle outputs are: hdr_rdy=0, data_rdy=0, noc val=0, store_hdr=0, flit_sel=HDR.

Structure
REQ-031 Package udp_rx_tile_pkg holds the state enum, flit_sel enum, and NOC_DATA_W/LEN_W/FLITS_W defaults.
REQ-032 Single module; no sub-module; the datapath registers and mux are outside this block.

Verification
REQ-033 len=0, noc rdy=1: HDR then META flits on consecutive cycles, msg_len=1, data_rdy never 1, back in READY after 2 flits.
REQ-034 len=64: 1 data flit, msg_len=2; len=65: 2 data flits, msg_len=3; last on final flit, ctrl_err=0.
REQ-035 len=200, noc rdy toggling 1/0 each cycle, data_val random: exactly 4 data transfers, noc val stable while stalled, no flit dropped or duplicated.
REQ-036 len=128 with data_last on first data flit: ctrl_err=1 and stays 1; block still emits 2 data flits then READY.
REQ-037 len=65535: msg_len=1025, 1024 data transfers, no counter overflow.
REQ-038 rst asserted mid-DATA_FLITS: next cycle state READY, noc val=0, ctrl_err=0; a following len=64 packet completes normally.
